axis_rr_arbiter: RTL
====================

// Module: axis_rr_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter sharing one AXI4-Stream master port between M
//  AXI4-Stream slave ports, all sized by one axis_cfg_t.
//  A grant is held from the first beat of a packet until the beat carrying TLAST is
//  accepted, so packets are never interleaved.
//  Sits upstream of shared stream resources such as DMA write engines and FIFOs.
// PARAMETERS
//  CFG     axis_cfg_t '{N:4,I:1,D:1,U:1,USE_TSTRB:0,USE_TKEEP:0}  stream sizing (N bytes/beat)
//  M       4   number of slave (requester) ports, 2..16
//  MW      $clog2(M)   width of granted-index output (derived, not overridden)
// PORTS
//  aclk        in   1          clock; all logic on rising edge
//  areset      in   1          asynchronous, active-high reset
//  enable      in   M          per-port arbitration enable (config register)
//  s_tvalid    in   M          slave TVALID
//  s_tready    out  M          slave TREADY
//  s_tdata     in   M x 8N     slave TDATA
//  s_tstrb     in   M x N      slave TSTRB (ignored; output driven all-ones when USE_TSTRB=0)
//  s_tkeep     in   M x N      slave TKEEP (ignored; output driven all-ones when USE_TKEEP=0)
//  s_tlast     in   M          slave TLAST
//  s_tid       in   M x I      slave TID
//  s_tdest     in   M x D      slave TDEST
//  s_tuser     in   M x U      slave TUSER
//  m_tvalid    out  1          master TVALID
//  m_tready    in   1          master TREADY
//  m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser   out   per CFG   muxed sideband
//  grant       out  M          one-hot current grant; 0 when idle
//  grant_idx   out  MW         binary index of grant; holds last value when idle
//  busy        out  1          1 while a packet is in flight
// BEHAVIOUR
//  Reset values: state IDLE; grant=0, grant_idx=0, busy=0, m_tvalid=0, s_tready=0.
//    Priority pointer ptr=0, so port 0 has the highest priority.
//  FSM: IDLE, BUSY.
//  IDLE:
//    - Candidates are req = s_tvalid & enable.
//    - If req!=0, pick the first set bit searching ptr, ptr+1, ... M-1, 0, ... (wraps).
//    - Register grant and grant_idx; go to BUSY next cycle.
//    - In IDLE, m_tvalid=0 and s_tready=0.
//  BUSY, combinational passthrough from the granted port:
//    - m_tvalid=s_tvalid[g], s_tready[g]=m_tready; all other s_tready=0.
//    - m_* payload = s_*[g].
//  Latency: one cycle from the first s_tvalid seen in IDLE to m_tvalid.
//    There is one idle bubble cycle between consecutive packets.
//  Packet end: when m_tvalid & m_tready & m_tlast:
//    - go to IDLE and set ptr=(g+1) mod M.
//    - grant clears next cycle.
//  Handshake rules:
//    - A granted source dropping TVALID mid-packet stalls the arbiter; the grant is held
//      indefinitely (no timeout).
//    - m_tready low stalls the arbiter; payload stays stable because the source must hold
//      it per AXI4-Stream.
//  enable changes:
//    - They only affect selection in IDLE.
//    - Deasserting enable[g] during BUSY does not abort the packet.
//  Simultaneous requests: the round-robin order guarantees each enabled, requesting port
//    is served within M packets.
//  Single-beat packets (TLAST on the first beat) are legal; the grant lasts exactly one
//    accepted beat.
//  Reset mid-packet:
//    - All outputs return to their reset values immediately.
//    - The partial packet is truncated; upstream recovery is the system's responsibility.
//  TLAST on a beat that is not accepted (m_tready=0) does not end the packet.
// TESTING
//  1. Reset, then s_tvalid[2]=1 with a 3-beat packet and m_tready=1:
//     grant=4'b0100 one cycle later; 3 beats out; grant=0 after TLAST; ptr=3.
//  2. All 4 ports request continuously with 2-beat packets:
//     grant order 0,1,2,3,0; one bubble cycle between packets.
//  3. m_tready toggles 1,0,1,0 during a 4-beat packet from port 1:
//     data order preserved, no duplicated beat, s_tready[1] mirrors m_tready.
//  4. enable=4'b1010 while ports 0..3 all request:
//     only ports 1 and 3 granted, alternating.
//  5. Port 0 mid-packet while port 3 requests, then port 0 tvalid low for 10 cycles:
//     grant stays 4'b0001 and port 3 is not served until port 0's TLAST is accepted.
//  6. areset asserted on beat 2 of 4:
//     m_tvalid=0, grant=0, busy=0 in the same cycle; after release, port 0 has priority.

Source files
------------

// File: rtl/axis_rr_arbiter_if.sv
// AXI4-Stream bundle of P parallel channels; the arbiter uses P=M on its
// requester side and P=1 on its shared master side.
interface axis_rr_arbiter_if #(
    parameter int P = 1,
    parameter int N = 4,
    parameter int I = 1,
    parameter int D = 1,
    parameter int U = 1
);
    logic [P-1:0]          tvalid;
    logic [P-1:0]          tready;
    logic [P-1:0]          tlast;
    logic [P-1:0][8*N-1:0] tdata;
    logic [P-1:0][N-1:0]   tstrb;
    logic [P-1:0][N-1:0]   tkeep;
    logic [P-1:0][I-1:0]   tid;
    logic [P-1:0][D-1:0]   tdest;
    logic [P-1:0][U-1:0]   tuser;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter: M AXI4-Stream requesters share one
// master port; a grant is held from first beat until the TLAST beat is accepted.
package axis_rr_pkg;
    typedef struct packed {
        int unsigned N;
        int unsigned I;
        int unsigned D;
        int unsigned U;
        logic        USE_TSTRB;
        logic        USE_TKEEP;
    } axis_cfg_t;
endpackage

module axis_rr_arbiter
    import axis_rr_pkg::*;
#(
    parameter axis_cfg_t CFG = '{N: 4, I: 1, D: 1, U: 1, USE_TSTRB: 1'b0, USE_TKEEP: 1'b0},
    parameter int        M   = 4,
    localparam int       MW  = $clog2(M)
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic [M-1:0]  enable,
    axis_rr_arbiter_if.slave  s,
    axis_rr_arbiter_if.master m,
    output logic [M-1:0]  grant,
    output logic [MW-1:0] grant_idx,
    output logic          busy
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state, state_n;
    logic [MW-1:0] ptr, ptr_n;
    logic [MW-1:0] gidx_n;
    logic [MW-1:0] sel_idx;
    logic [MW-1:0] cand;
    logic          sel_found;
    logic [M-1:0]  req;
    logic          last_fire;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            grant_idx <= '0;
            ptr       <= '0;
        end else begin
            state     <= state_n;
            grant_idx <= gidx_n;
            ptr       <= ptr_n;
        end
    end

    // Circular search starting at ptr; the first requester found wins.
    always_comb begin
        req       = s.tvalid & enable;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < M; k++) begin
            cand = MW'((32'(ptr) + k) % M);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign last_fire = (state == BUSY) && s.tvalid[grant_idx] && m.tready[0]
                       && s.tlast[grant_idx];

    always_comb begin
        state_n = state;
        gidx_n  = grant_idx;
        ptr_n   = ptr;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_n = BUSY;
                    gidx_n  = sel_idx;
                end
            end
            BUSY: begin
                if (last_fire) begin
                    state_n = IDLE;
                    ptr_n   = (grant_idx == MW'(M - 1)) ? '0 : grant_idx + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        grant = '0;
        if (state == BUSY) grant[grant_idx] = 1'b1;
    end

    assign busy = (state == BUSY);

    always_comb begin
        s.tready = '0;
        if (state == BUSY) s.tready[grant_idx] = m.tready[0];
    end

    assign m.tvalid[0] = (state == BUSY) && s.tvalid[grant_idx];
    assign m.tdata[0]  = s.tdata[grant_idx];
    assign m.tlast[0]  = s.tlast[grant_idx];
    assign m.tid[0]    = s.tid[grant_idx];
    assign m.tdest[0]  = s.tdest[grant_idx];
    assign m.tuser[0]  = s.tuser[grant_idx];
    assign m.tstrb[0]  = CFG.USE_TSTRB ? s.tstrb[grant_idx] : '1;
    assign m.tkeep[0]  = CFG.USE_TKEEP ? s.tkeep[grant_idx] : '1;

endmodule
